// File: rtl/anim_seq_pkg.sv
// Shared encodings for the animation state sequencer: mode select, FSM states and direction.
package anim_seq_pkg;

    localparam logic [1:0] MODE_LOOP     = 2'b00;
    localparam logic [1:0] MODE_PINGPONG = 2'b01;
    localparam logic [1:0] MODE_ONESHOT  = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/anim_state_sequencer_tick_prescaler.sv
// Frame-tick prescaler: counts while en is high, issues a one-cycle tick every TICK_DIV cycles.
module tick_prescaler
    import anim_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 6250000,
    parameter int unsigned DIV_W    = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // A clear takes precedence, so no tick can escape in the cycle the counter is being reset.
    assign tick = en && !clr && (div_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/anim_state_sequencer.sv
// Animation frame-state sequencer (loop / ping-pong / one-shot / hold) with LED indicator.
// Define ANIM_SEQ_LED_BAR_EN to turn the one-hot LED indicator into a thermometer bar.
module anim_state_sequencer
    import anim_seq_pkg::*;
#(
    parameter int unsigned NUM_STATES = 8,
    parameter int unsigned STATE_W    = 4,
    parameter int unsigned LED_W      = 16,
    parameter int unsigned TICK_DIV   = 6250000,
    parameter int unsigned DIV_W      = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic               restart,
    input  logic               step,
    output logic [STATE_W-1:0] state,
    output logic [LED_W-1:0]   led,
    output logic               wrap,
    output logic               done
);

    localparam logic [STATE_W-1:0] S_ONE  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_LAST = STATE_W'(NUM_STATES);

    logic [1:0] fsm;
    logic       dir;
    logic       tick;
    logic       pre_en;
    logic       pre_clr;
    logic       advance;

    assign pre_en  = (fsm == ST_RUN) && enable;
    assign pre_clr = restart || ((fsm == ST_IDLE) && enable);
    assign advance = tick || (step && !enable && (fsm == ST_RUN));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (pre_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm   <= ST_IDLE;
            state <= '0;
            dir   <= DIR_UP;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            if (restart) begin
                fsm   <= ST_RUN;
                state <= S_ONE;
                dir   <= DIR_UP;
            end else begin
                case (fsm)
                    ST_IDLE: begin
                        if (enable) begin
                            fsm   <= ST_RUN;
                            state <= S_ONE;
                        end
                    end
                    ST_RUN: begin
                        if (advance) begin
                            case (mode)
                                MODE_LOOP: begin
                                    dir <= DIR_UP;
                                    if (state == S_LAST) begin
                                        state <= S_ONE;
                                        wrap  <= 1'b1;
                                    end else begin
                                        state <= state + S_ONE;
                                    end
                                end
                                MODE_PINGPONG: begin
                                    if (dir == DIR_UP) begin
                                        if (state == S_LAST) begin
                                            dir   <= DIR_DOWN;
                                            state <= state - S_ONE;
                                        end else begin
                                            state <= state + S_ONE;
                                        end
                                    end else if (state == S_ONE) begin
                                        dir   <= DIR_UP;
                                        state <= state + S_ONE;
                                        wrap  <= 1'b1;
                                    end else begin
                                        state <= state - S_ONE;
                                    end
                                end
                                MODE_ONESHOT: begin
                                    if (state == S_LAST) begin
                                        fsm  <= ST_DONE;
                                        done <= 1'b1;
                                    end else begin
                                        state <= state + S_ONE;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bit i is lit when i + state reaches LED_W, avoiding any underflow in LED_W - state.
    always_comb begin
        int unsigned s;
        led = '0;
        s   = 32'(state);
        for (int unsigned i = 0; i < LED_W; i++) begin
`ifdef ANIM_SEQ_LED_BAR_EN
            led[i] = (s != 0) && (i + s >= LED_W);
`else
            led[i] = (s != 0) && (i + s == LED_W);
`endif
        end
    end

endmodule

// File: tb/tb_anim_state_sequencer.sv
// Directed self-checking bench for anim_state_sequencer (TICK_DIV=4, NUM_STATES=4, LED_W=16).
module tb_anim_state_sequencer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic        restart;
    logic        step;
    logic [3:0]  state;
    logic [15:0] led;
    logic        wrap;
    logic        done;

    int checks;
    int errors;

    anim_state_sequencer #(
        .NUM_STATES (4),
        .STATE_W    (4),
        .LED_W      (16),
        .TICK_DIV   (4),
        .DIV_W      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mode    (mode),
        .restart (restart),
        .step    (step),
        .state   (state),
        .led     (led),
        .wrap    (wrap),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        enable  = 1'b0;
        mode    = 2'b00;
        restart = 1'b0;
        step    = 1'b0;

        cyc(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        cyc(1);
        chk("idle_hold", 32'(state), 32'd0);

        // Loop mode
        enable = 1'b1;
        cyc(1);
        chk("loop_s1", 32'(state), 32'd1);
        chk("loop_led1", 32'(led), 32'h8000);
        cyc(3);
        chk("loop_s1_held", 32'(state), 32'd1);
        cyc(1);
        chk("loop_s2", 32'(state), 32'd2);
        cyc(4);
        chk("loop_s3", 32'(state), 32'd3);
        cyc(4);
        chk("loop_s4", 32'(state), 32'd4);
        chk("loop_led4", 32'(led), 32'h1000);
        chk("loop_nowrap", 32'(wrap), 32'd0);
        cyc(4);
        chk("loop_wrap_s", 32'(state), 32'd1);
        chk("loop_wrap", 32'(wrap), 32'd1);
        cyc(1);
        chk("loop_wrap_end", 32'(wrap), 32'd0);

        // Asynchronous reset mid-run
        cyc(3);
        chk("pre_rst_s2", 32'(state), 32'd2);
        cyc(4);
        chk("pre_rst_s3", 32'(state), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_wrap", 32'(wrap), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        cyc(1);
        chk("rst_held_state", 32'(state), 32'd0);
        rst = 1'b1;
        cyc(1);
        chk("rel_s1", 32'(state), 32'd1);
        cyc(4);
        chk("rel_s2", 32'(state), 32'd2);
        cyc(4);
        chk("rel_s3", 32'(state), 32'd3);
        cyc(4);
        chk("rel_s4", 32'(state), 32'd4);

        // Ping-pong
        restart = 1'b1;
        mode    = 2'b01;
        cyc(1);
        restart = 1'b0;
        chk("pp_restart_s1", 32'(state), 32'd1);
        chk("pp_restart_nowrap", 32'(wrap), 32'd0);
        cyc(4);
        chk("pp_s2", 32'(state), 32'd2);
        cyc(4);
        chk("pp_s3", 32'(state), 32'd3);
        cyc(4);
        chk("pp_s4", 32'(state), 32'd4);
        cyc(4);
        chk("pp_s3_down", 32'(state), 32'd3);
        chk("pp_top_nowrap", 32'(wrap), 32'd0);
        cyc(4);
        chk("pp_s2_down", 32'(state), 32'd2);
        cyc(4);
        chk("pp_s1_down", 32'(state), 32'd1);
        chk("pp_s1_nowrap", 32'(wrap), 32'd0);
        cyc(4);
        chk("pp_turn_s2", 32'(state), 32'd2);
        chk("pp_turn_wrap", 32'(wrap), 32'd1);
        cyc(1);
        chk("pp_turn_wrap_end", 32'(wrap), 32'd0);
        cyc(3);
        chk("pp2_s3", 32'(state), 32'd3);
        cyc(4);
        chk("pp2_s4", 32'(state), 32'd4);
        cyc(4);
        chk("pp2_s3_down", 32'(state), 32'd3);
        mode = 2'b00;
        cyc(4);
        chk("pp_to_loop_s4", 32'(state), 32'd4);
        cyc(4);
        chk("pp_to_loop_wrap_s", 32'(state), 32'd1);
        chk("pp_to_loop_wrap", 32'(wrap), 32'd1);

        // One-shot
        mode = 2'b10;
        cyc(4);
        chk("os_s2", 32'(state), 32'd2);
        cyc(4);
        chk("os_s3", 32'(state), 32'd3);
        cyc(4);
        chk("os_s4", 32'(state), 32'd4);
        chk("os_nodone", 32'(done), 32'd0);
        cyc(4);
        chk("os_done", 32'(done), 32'd1);
        chk("os_done_s4", 32'(state), 32'd4);
        cyc(1);
        chk("os_done_end", 32'(done), 32'd0);
        cyc(20);
        chk("os_stay_s4", 32'(state), 32'd4);
        chk("os_stay_nodone", 32'(done), 32'd0);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        chk("os_restart_s1", 32'(state), 32'd1);
        cyc(4);
        chk("os_resume_s2", 32'(state), 32'd2);

        // Pause and manual step
        cyc(2);
        enable = 1'b0;
        cyc(5);
        chk("pause_hold_s2", 32'(state), 32'd2);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step_s3", 32'(state), 32'd3);
        cyc(2);
        chk("step_once", 32'(state), 32'd3);
        enable = 1'b1;
        step   = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step_ignored", 32'(state), 32'd3);
        cyc(1);
        chk("reenable_tick_s4", 32'(state), 32'd4);

        // Restart coincident with tick
        mode = 2'b00;
        cyc(4);
        chk("rt_wrap_s1", 32'(state), 32'd1);
        cyc(4);
        chk("rt_s2", 32'(state), 32'd2);
        cyc(3);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        chk("rt_state", 32'(state), 32'd1);
        chk("rt_nowrap", 32'(wrap), 32'd0);
        cyc(3);
        chk("rt_cnt_cleared", 32'(state), 32'd1);
        cyc(1);
        chk("rt_after_s2", 32'(state), 32'd2);
        cyc(4);
        chk("led_s3_state", 32'(state), 32'd3);
`ifdef ANIM_SEQ_LED_BAR_EN
        chk("led_s3", 32'(led), 32'hE000);
`else
        chk("led_s3", 32'(led), 32'h2000);
`endif

        // Hold mode
        mode = 2'b11;
        cyc(12);
        chk("hold_s3", 32'(state), 32'd3);
        chk("hold_nowrap", 32'(wrap), 32'd0);
        chk("hold_nodone", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
